// File: rtl/time_keeper_if.sv
// rtl/time_keeper_if.sv - control and BCD display bundle for the time-of-day counter
interface time_keeper_if;
  logic       tick_in;
  logic       set_en;
  logic [1:0] set_sel;
  logic       inc;
  logic [3:0] hr_tens;
  logic [3:0] hr_ones;
  logic [3:0] min_tens;
  logic [3:0] min_ones;
  logic [3:0] sec_tens;
  logic [3:0] sec_ones;
  logic       sec_strobe;
  logic       day_wrap;

  modport master (
    output tick_in, set_en, set_sel, inc,
    input  hr_tens, hr_ones, min_tens, min_ones, sec_tens, sec_ones,
    input  sec_strobe, day_wrap
  );

  modport slave (
    input  tick_in, set_en, set_sel, inc,
    output hr_tens, hr_ones, min_tens, min_ones, sec_tens, sec_ones,
    output sec_strobe, day_wrap
  );
endinterface

// File: rtl/time_keeper.sv
// rtl/time_keeper.sv - 24-hour BCD time of day driven by a 1 Hz square wave
// Run mode counts on tick_in rising edges; set mode halts time and applies inc pulses to one field.
module time_keeper #(
  parameter int INIT_HH = 0,
  parameter int INIT_MM = 0,
  parameter int INIT_SS = 0
) (
  input  logic          CLOCK_50,
  input  logic          reset,
  time_keeper_if.slave  bus
);

  localparam logic [1:0] SEL_SEC  = 2'd0;
  localparam logic [1:0] SEL_MIN  = 2'd1;
  localparam logic [1:0] SEL_HOUR = 2'd2;

  localparam logic [3:0] INIT_HT = 4'(INIT_HH / 10);
  localparam logic [3:0] INIT_HO = 4'(INIT_HH % 10);
  localparam logic [3:0] INIT_MT = 4'(INIT_MM / 10);
  localparam logic [3:0] INIT_MO = 4'(INIT_MM % 10);
  localparam logic [3:0] INIT_ST = 4'(INIT_SS / 10);
  localparam logic [3:0] INIT_SO = 4'(INIT_SS % 10);

  logic       r_tick_q;
  logic [3:0] r_hr_tens, r_hr_ones, r_min_tens, r_min_ones, r_sec_tens, r_sec_ones;
  logic       r_sec_strobe, r_day_wrap;

  logic       w_rise;
  logic [3:0] w_hr_tens, w_hr_ones, w_min_tens, w_min_ones, w_sec_tens, w_sec_ones;
  logic       w_sec_strobe, w_day_wrap;
  logic       w_sec_last, w_min_last, w_hr_last;

  assign w_rise     = bus.tick_in & ~r_tick_q;
  assign w_sec_last = (r_sec_tens == 4'd5) && (r_sec_ones == 4'd9);
  assign w_min_last = (r_min_tens == 4'd5) && (r_min_ones == 4'd9);
  assign w_hr_last  = (r_hr_tens  == 4'd2) && (r_hr_ones  == 4'd3);

  always_comb begin
    w_hr_tens    = r_hr_tens;
    w_hr_ones    = r_hr_ones;
    w_min_tens   = r_min_tens;
    w_min_ones   = r_min_ones;
    w_sec_tens   = r_sec_tens;
    w_sec_ones   = r_sec_ones;
    w_sec_strobe = 1'b0;
    w_day_wrap   = 1'b0;

    if (!bus.set_en) begin
      if (w_rise) begin
        w_sec_strobe = 1'b1;
        if (r_sec_ones != 4'd9) begin
          w_sec_ones = r_sec_ones + 4'd1;
        end else begin
          w_sec_ones = 4'd0;
          w_sec_tens = (r_sec_tens == 4'd5) ? 4'd0 : r_sec_tens + 4'd1;
        end
        // Minute and hour carries ripple only from the final second of the field below.
        if (w_sec_last) begin
          if (r_min_ones != 4'd9) begin
            w_min_ones = r_min_ones + 4'd1;
          end else begin
            w_min_ones = 4'd0;
            w_min_tens = (r_min_tens == 4'd5) ? 4'd0 : r_min_tens + 4'd1;
          end
          if (w_min_last) begin
            if (w_hr_last) begin
              w_hr_tens  = 4'd0;
              w_hr_ones  = 4'd0;
              w_day_wrap = 1'b1;
            end else if (r_hr_ones == 4'd9) begin
              w_hr_ones = 4'd0;
              w_hr_tens = r_hr_tens + 4'd1;
            end else begin
              w_hr_ones = r_hr_ones + 4'd1;
            end
          end
        end
      end
    end else if (bus.inc) begin
      case (bus.set_sel)
        SEL_SEC: begin
          w_sec_tens = 4'd0;
          w_sec_ones = 4'd0;
        end
        SEL_MIN: begin
          if (w_min_last) begin
            w_min_tens = 4'd0;
            w_min_ones = 4'd0;
          end else if (r_min_ones == 4'd9) begin
            w_min_ones = 4'd0;
            w_min_tens = r_min_tens + 4'd1;
          end else begin
            w_min_ones = r_min_ones + 4'd1;
          end
        end
        SEL_HOUR: begin
          if (w_hr_last) begin
            w_hr_tens = 4'd0;
            w_hr_ones = 4'd0;
          end else if (r_hr_ones == 4'd9) begin
            w_hr_ones = 4'd0;
            w_hr_tens = r_hr_tens + 4'd1;
          end else begin
            w_hr_ones = r_hr_ones + 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // tick_q tracks tick_in even in reset so a high level at release is not seen as an edge.
  always_ff @(posedge CLOCK_50) begin
    r_tick_q <= bus.tick_in;
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      r_hr_tens    <= INIT_HT;
      r_hr_ones    <= INIT_HO;
      r_min_tens   <= INIT_MT;
      r_min_ones   <= INIT_MO;
      r_sec_tens   <= INIT_ST;
      r_sec_ones   <= INIT_SO;
      r_sec_strobe <= 1'b0;
      r_day_wrap   <= 1'b0;
    end else begin
      r_hr_tens    <= w_hr_tens;
      r_hr_ones    <= w_hr_ones;
      r_min_tens   <= w_min_tens;
      r_min_ones   <= w_min_ones;
      r_sec_tens   <= w_sec_tens;
      r_sec_ones   <= w_sec_ones;
      r_sec_strobe <= w_sec_strobe;
      r_day_wrap   <= w_day_wrap;
    end
  end

  assign bus.hr_tens    = r_hr_tens;
  assign bus.hr_ones    = r_hr_ones;
  assign bus.min_tens   = r_min_tens;
  assign bus.min_ones   = r_min_ones;
  assign bus.sec_tens   = r_sec_tens;
  assign bus.sec_ones   = r_sec_ones;
  assign bus.sec_strobe = r_sec_strobe;
  assign bus.day_wrap   = r_day_wrap;

endmodule

// File: tb/tb_time_keeper.sv
// tb/tb_time_keeper.sv - directed table plus randomized model check of time_keeper
module tb_time_keeper;

  logic       CLOCK_50;
  logic       r_rst;
  logic       r_tick;
  logic       r_set_en;
  logic [1:0] r_sel;
  logic       r_inc;

  time_keeper_if if0 ();
  time_keeper_if if1 ();

  assign if0.tick_in = r_tick;
  assign if0.set_en  = r_set_en;
  assign if0.set_sel = r_sel;
  assign if0.inc     = r_inc;
  assign if1.tick_in = r_tick;
  assign if1.set_en  = r_set_en;
  assign if1.set_sel = r_sel;
  assign if1.inc     = r_inc;

  time_keeper u_dut0 (.CLOCK_50(CLOCK_50), .reset(r_rst), .bus(if0.slave));
  time_keeper #(.INIT_HH(23), .INIT_MM(59), .INIT_SS(58))
    u_dut1 (.CLOCK_50(CLOCK_50), .reset(r_rst), .bus(if1.slave));

  initial begin
    CLOCK_50 = 1'b0;
    forever #10 CLOCK_50 = ~CLOCK_50;
  end

  int checks = 0;
  int errors = 0;

  // Reference model: time of day as seconds since midnight.
  int  m_init [2] = '{0, 23*3600 + 59*60 + 58};
  int  m_tod  [2];
  bit  m_st   [2];
  bit  m_wr   [2];
  bit  m_tq = 1'b0;

  function automatic logic [25:0] pack_exp(int tod, bit s, bit w);
    int hh, mm, ss;
    hh = tod / 3600;
    mm = (tod / 60) % 60;
    ss = tod % 60;
    return {4'(hh / 10), 4'(hh % 10), 4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10), s, w};
  endfunction

  function automatic logic [25:0] pack_act0();
    return {if0.hr_tens, if0.hr_ones, if0.min_tens, if0.min_ones,
            if0.sec_tens, if0.sec_ones, if0.sec_strobe, if0.day_wrap};
  endfunction

  function automatic logic [25:0] pack_act1();
    return {if1.hr_tens, if1.hr_ones, if1.min_tens, if1.min_ones,
            if1.sec_tens, if1.sec_ones, if1.sec_strobe, if1.day_wrap};
  endfunction

  task automatic check(input string name, input int idx, input logic [25:0] act, input logic [25:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d got %h expected %h", name, idx, act, exp);
    end
  endtask

  task automatic model_update(input int d, input bit rst, input bit rise, input bit se,
                              input bit [1:0] sel, input bit iv);
    int hh, mm, ss;
    m_st[d] = 1'b0;
    m_wr[d] = 1'b0;
    if (rst) begin
      m_tod[d] = m_init[d];
    end else if (!se) begin
      if (rise) begin
        m_tod[d] = (m_tod[d] + 1) % 86400;
        m_st[d]  = 1'b1;
        m_wr[d]  = (m_tod[d] == 0);
      end
    end else if (iv) begin
      hh = m_tod[d] / 3600;
      mm = (m_tod[d] / 60) % 60;
      ss = m_tod[d] % 60;
      case (sel)
        2'd0: ss = 0;
        2'd1: mm = (mm + 1) % 60;
        2'd2: hh = (hh + 1) % 24;
        default: ;
      endcase
      m_tod[d] = hh * 3600 + mm * 60 + ss;
    end
  endtask

  task automatic step(input bit rst, input bit tk, input bit se, input bit [1:0] sel, input bit iv);
    bit rise;
    r_rst    = rst;
    r_tick   = tk;
    r_set_en = se;
    r_sel    = sel;
    r_inc    = iv;
    @(posedge CLOCK_50);
    rise = tk && !m_tq;
    m_tq = tk;
    for (int d = 0; d < 2; d++) model_update(d, rst, rise, se, sel, iv);
    @(negedge CLOCK_50);
  endtask

  typedef struct {
    bit       rst;
    bit       tick;
    bit       se;
    bit [1:0] sel;
    bit       inc;
    int       hh, mm, ss;
    bit       st, wr;
  } vec_t;

  vec_t vecs [$];

  function automatic vec_t mk(bit rst, bit tk, bit se, bit [1:0] sel, bit iv,
                              int hh, int mm, int ss, bit st, bit wr);
    vec_t v;
    v.rst = rst; v.tick = tk; v.se = se; v.sel = sel; v.inc = iv;
    v.hh = hh; v.mm = mm; v.ss = ss; v.st = st; v.wr = wr;
    return v;
  endfunction

  initial begin
    r_rst = 1'b1; r_tick = 1'b1; r_set_en = 1'b0; r_sel = 2'd3; r_inc = 1'b0;

    // Expected values for the default-INIT instance, one row per clock edge.
    vecs.push_back(mk(1,1,0,3,0, 0,0,0, 0,0));
    vecs.push_back(mk(1,1,0,3,0, 0,0,0, 0,0));
    vecs.push_back(mk(0,1,0,3,0, 0,0,0, 0,0));
    vecs.push_back(mk(0,1,0,3,0, 0,0,0, 0,0));
    vecs.push_back(mk(0,0,0,3,0, 0,0,0, 0,0));
    vecs.push_back(mk(0,1,0,3,0, 0,0,1, 1,0));
    vecs.push_back(mk(0,1,0,3,0, 0,0,1, 0,0));
    vecs.push_back(mk(0,1,0,1,1, 0,0,1, 0,0));
    vecs.push_back(mk(0,0,0,3,0, 0,0,1, 0,0));
    vecs.push_back(mk(0,1,1,1,1, 0,1,1, 0,0));
    vecs.push_back(mk(0,0,1,1,1, 0,2,1, 0,0));
    vecs.push_back(mk(0,0,1,2,1, 1,2,1, 0,0));
    vecs.push_back(mk(0,1,1,0,1, 1,2,0, 0,0));
    vecs.push_back(mk(0,0,1,3,1, 1,2,0, 0,0));
    vecs.push_back(mk(0,0,0,3,0, 1,2,0, 0,0));
    vecs.push_back(mk(0,1,0,3,0, 1,2,1, 1,0));
    vecs.push_back(mk(1,0,0,3,0, 0,0,0, 0,0));
    vecs.push_back(mk(0,1,0,3,0, 0,0,1, 1,0));
    vecs.push_back(mk(0,0,0,3,0, 0,0,1, 0,0));
    vecs.push_back(mk(1,1,0,3,0, 0,0,0, 0,0));
    vecs.push_back(mk(0,1,0,3,0, 0,0,0, 0,0));
    vecs.push_back(mk(0,0,0,3,0, 0,0,0, 0,0));
    vecs.push_back(mk(0,1,0,3,0, 0,0,1, 1,0));
    vecs.push_back(mk(0,0,0,3,0, 0,0,1, 0,0));
    vecs.push_back(mk(0,1,0,3,0, 0,0,2, 1,0));
    vecs.push_back(mk(0,1,0,3,0, 0,0,2, 0,0));

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].rst, vecs[i].tick, vecs[i].se, vecs[i].sel, vecs[i].inc);
      check("table_dut0", i, pack_act0(),
            pack_exp(vecs[i].hh * 3600 + vecs[i].mm * 60 + vecs[i].ss, vecs[i].st, vecs[i].wr));
      check("table_dut1", i, pack_act1(), pack_exp(m_tod[1], m_st[1], m_wr[1]));
    end

    // Day rollover on the 23:59:58 instance: reset, two rises, wrap on the second.
    step(1, 0, 0, 3, 0);
    check("wrap_reset", 0, pack_act1(), pack_exp(23*3600 + 59*60 + 58, 0, 0));
    step(0, 1, 0, 3, 0);
    check("wrap_first", 0, pack_act1(), pack_exp(23*3600 + 59*60 + 59, 1, 0));
    step(0, 0, 0, 3, 0);
    step(0, 1, 0, 3, 0);
    check("wrap_pulse", 0, pack_act1(), pack_exp(0, 1, 1));
    step(0, 1, 0, 3, 0);
    check("wrap_clear", 0, pack_act1(), pack_exp(0, 0, 0));

    // Set-mode field wrap: minutes 59->00 and hours 23->00 without carry or wrap.
    step(1, 0, 1, 1, 1);
    check("setwrap_rst", 0, pack_act1(), pack_exp(23*3600 + 59*60 + 58, 0, 0));
    step(0, 1, 1, 1, 1);
    check("setwrap_min", 0, pack_act1(), pack_exp(23*3600 + 58, 0, 0));
    step(0, 0, 1, 2, 1);
    check("setwrap_hr", 0, pack_act1(), pack_exp(58, 0, 0));

    begin
      bit se;
      se = 1'b0;
      for (int i = 0; i < 20000; i++) begin
        if ($urandom_range(49) == 0) se = ~se;
        step($urandom_range(999) == 0, 1'($urandom_range(1)), se,
             2'($urandom_range(3)), $urandom_range(3) == 0);
        check("rand_dut0", i, pack_act0(), pack_exp(m_tod[0], m_st[0], m_wr[0]));
        check("rand_dut1", i, pack_act1(), pack_exp(m_tod[1], m_st[1], m_wr[1]));
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/time_keeper.md
Name: time_keeper

Overview:
- Consumes the 1 Hz square wave from the clock divider and keeps 24-hour time of day as six BCD digits (HH:MM:SS) for the 7-segment display path.
- Runs entirely in the CLOCK_50 domain. Rising edges of the slow square wave become single-cycle count strobes.
- Has a set mode so the user can load hours and minutes, and clear seconds, from debounced push-button pulses.

Parameters:
- INIT_HH, 0, hour loaded on reset (0..23).
- INIT_MM, 0, minute loaded on reset (0..59).
- INIT_SS, 0, second loaded on reset (0..59).

Ports:
- CLOCK_50  in  1  50 MHz system clock; all logic on posedge.
- reset  in  1  synchronous, active-high reset.
- tick_in  in  1  1 Hz square wave from the clock divider, registered in the CLOCK_50 domain.
- set_en  in  1  1 = set mode (time halted), 0 = run mode.
- set_sel  in  2  field select in set mode: 0 = seconds, 1 = minutes, 2 = hours, 3 = none.
- inc  in  1  single-cycle debounced increment pulse.
- hr_tens  out  4  BCD hours tens, 0..2.
- hr_ones  out  4  BCD hours ones, 0..9.
- min_tens  out  4  BCD minutes tens, 0..5.
- min_ones  out  4  BCD minutes ones, 0..9.
- sec_tens  out  4  BCD seconds tens, 0..5.
- sec_ones  out  4  BCD seconds ones, 0..9.
- sec_strobe  out  1  one-cycle pulse, high in the cycle the time advanced by one second.
- day_wrap  out  1  one-cycle pulse, high when 23:59:59 rolls to 00:00:00.

Behaviour:
- Interface: one clock, CLOCK_50. Reset is synchronous and active-high on port reset. All outputs are registered.
- Reset:
  - Digits load INIT_HH:INIT_MM:INIT_SS, split into BCD.
  - sec_strobe = 0, day_wrap = 0.
  - tick_q samples tick_in on every edge, including during reset, so no spurious strobe occurs at reset release.
- Edge detect:
  - tick_q <= tick_in every cycle.
  - rise = tick_in & ~tick_q.
  - Exactly one rise per tick_in period. A level held high produces no further rises.
- Run mode (set_en = 0), on an edge where rise = 1:
  - Increment seconds; digits and sec_strobe are visible after that same edge (latency 1 cycle from tick_in first sampled high).
  - sec_ones 9 -> 0 with sec_tens +1. Seconds 59 -> 00 carries into minutes.
  - Minutes 59 -> 00 carries into hours.
  - Hours 23 -> 00. On the full 23:59:59 -> 00:00:00 step, day_wrap = 1 for one cycle.
  - inc is ignored in run mode.
- Set mode (set_en = 1):
  - rise is ignored; time is frozen; sec_strobe and day_wrap stay 0.
  - On inc = 1, the field is updated on the next edge:
    - sel 0: seconds cleared to 00.
    - sel 1: minutes +1, 59 -> 00, no carry into hours.
    - sel 2: hours +1, 23 -> 00, no day_wrap.
    - sel 3: no change.
  - inc held high for N cycles gives N increments; debounce is upstream.
- Mode switching:
  - set_en may change on any cycle.
  - Run -> set: takes effect on the same edge; a rise on that edge is dropped.
  - Set -> run: counting resumes at the next rise. There is no catch-up for ticks missed while halted.
- Simultaneous events:
  - reset has priority over everything.
  - rise and inc on the same edge: only the event valid for the current mode acts.
- Invariant: digits never leave their legal BCD range. Illegal INIT values are a configuration error and need not be handled.

Test Plan:
- Reset with defaults and tick_in = 1 held through release -> 00:00:00, no sec_strobe until tick_in falls and rises again.
- Seconds rollover: INIT 00:00:58, two tick_in rises -> 00:00:59, then 00:01:00. sec_strobe pulses once per rise, each exactly 1 cycle, in the cycle after tick_in is first sampled high.
- Day rollover: INIT 23:59:59, one rise -> 00:00:00, with day_wrap = 1 for exactly that cycle.
- Set mode: 12:59:30, set_en = 1, set_sel = 1, inc x2 -> 12:01:30 (no carry). set_sel = 2, inc x12 -> 00:01:30. set_sel = 0, inc -> 00:01:00. Rises during set mode change nothing.
- Resume: drop set_en, next rise -> 00:01:01. inc pulses in run mode have no effect.
- Reset mid-count at 07:45:12 -> INIT value on the next edge, outputs cleared. Simultaneous rise and reset -> reset wins.
